// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   seq_state_t : state encoding of alu_seq_ctrl
//   CMD_TAG     : upper nibble a command byte must carry
//   FUN_*       : ALU function-select codes; the shift group sits at
//                 alu_fun[3:2]=2'b11 with [1:0] picking A>>1, A<<1, B>>1, B<<1
package alu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_A,
      ST_GET_B,
      ST_EXEC,
      ST_WAIT_RES,
      ST_SEND_LO,
      ST_SEND_HI
   } seq_state_t;

   localparam logic [3:0] CMD_TAG = 4'hA;

   localparam logic [3:0] FUN_ADD    = 4'h0;
   localparam logic [3:0] FUN_SUB    = 4'h1;
   localparam logic [3:0] FUN_AND    = 4'h2;
   localparam logic [3:0] FUN_OR     = 4'h3;
   localparam logic [3:0] FUN_XOR    = 4'h4;
   localparam logic [3:0] FUN_MUL    = 4'h5;
   localparam logic [3:0] FUN_CMP_EQ = 4'h8;
   localparam logic [3:0] FUN_CMP_LT = 4'h9;
   localparam logic [3:0] FUN_CMP_GT = 4'hA;

   localparam logic [1:0] FUN_SHIFT_GRP = 2'b11;
   localparam logic [3:0] FUN_SHR_A     = {FUN_SHIFT_GRP, 2'b00};
   localparam logic [3:0] FUN_SHL_A     = {FUN_SHIFT_GRP, 2'b01};
   localparam logic [3:0] FUN_SHR_B     = {FUN_SHIFT_GRP, 2'b10};
   localparam logic [3:0] FUN_SHL_B     = {FUN_SHIFT_GRP, 2'b11};

   // True when the upper nibble of a received byte carries the command tag.
   function automatic logic tag_match(input logic [7:0] b, input logic [3:0] tag);
      return b[7:4] == tag;
   endfunction

endpackage

// File: rtl/alu_seq_tx_ser.sv
// Two-byte TX serializer: loads a 2*DATA_WIDTH result, offers the low byte
// then the high byte on a valid/ready handshake. Its byte registers are the
// result holding register of the sequencer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture result and start offering the low byte
//   result      : value to send
//   tx_ready    : transmitter accepts a byte this cycle
//   tx_data     : byte offered (stable while tx_valid)
//   tx_valid    : byte available
//   lo_done     : low byte accepted this cycle
//   hi_done     : high byte accepted this cycle
module alu_seq_tx_ser #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [2*DATA_WIDTH-1:0]   result,
   input  logic                      tx_ready,
   output logic [DATA_WIDTH-1:0]     tx_data,
   output logic                      tx_valid,
   output logic                      lo_done,
   output logic                      hi_done
);

   logic [DATA_WIDTH-1:0] hi_byte;
   logic                  sel_hi;
   logic                  accept;

   assign accept  = tx_valid && tx_ready;
   assign lo_done = accept && !sel_hi;
   assign hi_done = accept && sel_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data  <= '0;
         tx_valid <= 1'b0;
         hi_byte  <= '0;
         sel_hi   <= 1'b0;
      end else if (load) begin
         tx_data  <= result[DATA_WIDTH-1:0];
         hi_byte  <= result[2*DATA_WIDTH-1:DATA_WIDTH];
         tx_valid <= 1'b1;
         sel_hi   <= 1'b0;
      end else if (accept) begin
         if (!sel_hi) begin
            // Low byte taken: switch straight to the high byte, valid stays up.
            tx_data <= hi_byte;
            sel_hi  <= 1'b1;
         end else begin
            tx_valid <= 1'b0;
            sel_hi   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer between the UART byte streams and the ALU.
// Collects {command, A, B} from RX, pulses alu_en for one cycle, waits for
// alu_out_valid, then returns the result to TX low byte first.
// Optional feature: define ALU_SEQ_CTRL_TIMEOUT_EN to abort a frame (cmd_err
// pulse, back to IDLE) after TIMEOUT_CYC idle cycles in GET_A/GET_B/WAIT_RES.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_data, rx_valid     : received byte stream
//   alu_a, alu_b, alu_fun : registered ALU operands and function select
//   alu_en                : one-cycle ALU enable
//   alu_out, alu_out_valid: ALU registered result and its valid flag
//   tx_data, tx_valid, tx_ready : TX byte handshake
//   busy                  : high in every state except IDLE
//   cmd_err               : one-cycle pulse on bad command tag or timeout
module alu_seq_ctrl #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter logic [3:0]  CMD_TAG     = alu_pkg::CMD_TAG,
   parameter int unsigned RES_LAT     = 1,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_valid,
   output logic [DATA_WIDTH-1:0]     alu_a,
   output logic [DATA_WIDTH-1:0]     alu_b,
   output logic [3:0]                alu_fun,
   output logic                      alu_en,
   input  logic [2*DATA_WIDTH-1:0]   alu_out,
   input  logic                      alu_out_valid,
   output logic [DATA_WIDTH-1:0]     tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy,
   output logic                      cmd_err
);

   import alu_pkg::*;

   seq_state_t state;
   logic       ser_load;
   logic       lo_done;
   logic       hi_done;

   // The serializer captures the result in the same cycle the FSM enters SEND_LO.
   assign ser_load = (state == ST_WAIT_RES) && alu_out_valid;

`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
   localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [TO_W-1:0] to_cnt;
   logic            timed;
   logic            to_hit;

   assign timed  = (state == ST_GET_A) || (state == ST_GET_B) || (state == ST_WAIT_RES);
   // to_cnt is zero in the first cycle of a wait and cmd_err is registered,
   // so matching TIMEOUT_CYC-2 lands the pulse TIMEOUT_CYC cycles after the
   // last accepted byte.
   assign to_hit = timed && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 2));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_fun <= '0;
         alu_en  <= 1'b0;
         busy    <= 1'b0;
         cmd_err <= 1'b0;
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
         to_cnt  <= '0;
`endif
      end else begin
         alu_en  <= 1'b0;
         cmd_err <= 1'b0;
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
         // Outside the timed states the counter sits at zero, which doubles
         // as the clear on every state entry.
         if (timed && !rx_valid) to_cnt <= to_cnt + 1'b1;
         else                    to_cnt <= '0;
`endif
         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  if (tag_match(rx_data[7:0], CMD_TAG)) begin
                     alu_fun <= rx_data[3:0];
                     state   <= ST_GET_A;
                     busy    <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            ST_GET_A: begin
               if (rx_valid) begin
                  alu_a <= rx_data;
                  state <= ST_GET_B;
               end
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
               else if (to_hit) begin
                  cmd_err <= 1'b1;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
               end
`endif
            end
            ST_GET_B: begin
               if (rx_valid) begin
                  alu_b  <= rx_data;
                  alu_en <= 1'b1;     // registered: high exactly during EXEC
                  state  <= ST_EXEC;
               end
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
               else if (to_hit) begin
                  cmd_err <= 1'b1;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
               end
`endif
            end
            ST_EXEC: begin
               state <= ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
               if (alu_out_valid) begin
                  state <= ST_SEND_LO;
               end
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
               else if (to_hit) begin
                  cmd_err <= 1'b1;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
               end
`endif
            end
            ST_SEND_LO: begin
               if (lo_done) state <= ST_SEND_HI;
            end
            ST_SEND_HI: begin
               if (hi_done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   alu_seq_tx_ser #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ser_load),
      .result   (alu_out),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .lo_done  (lo_done),
      .hi_done  (hi_done)
   );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a one-cycle-latency ALU stub.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_fun;
   logic        alu_en;
   logic [15:0] alu_out;
   logic        alu_out_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        cmd_err;

   logic [15:0] alu_ret  = '0;
   logic        alu_hold = 1'b0;
   int          en_cnt   = 0;
   int          n_vec    = 0;
   int          n_err    = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(
      .DATA_WIDTH  (8),
      .CMD_TAG     (4'hA),
      .RES_LAT     (1),
      .TIMEOUT_CYC (255)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_fun       (alu_fun),
      .alu_en        (alu_en),
      .alu_out       (alu_out),
      .alu_out_valid (alu_out_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .busy          (busy),
      .cmd_err       (cmd_err)
   );

   // ALU stub: result valid one cycle after alu_en, value preset by the bench.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_valid <= 1'b0;
         alu_out       <= '0;
      end else begin
         alu_out_valid <= alu_en && !alu_hold;
         if (alu_en) alu_out <= alu_ret;
      end
   end

   always @(posedge clk) if (alu_en) en_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   // Waits (bounded) for tx_valid, checks the byte, then accepts it.
   task automatic recv_byte(input string tag, input logic [7:0] exp);
      for (int i = 0; i < 20 && !tx_valid; i++) tick();
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk(tag, 32'(tx_data), 32'(exp));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stable;

      // Reset state
      #3 rst_n = 1'b0;
      #1;
      chk("reset_outputs", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, cmd_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Frame AC 96 03: shift A right -> 0x004B
      alu_ret = 16'h004B;
      send_byte(8'hAC);
      chk("fun_latch", 32'(alu_fun), 32'hC);
      chk("busy_get_a", 32'(busy), 32'd1);
      send_byte(8'h96);
      chk("alu_a", 32'(alu_a), 32'h96);
      send_byte(8'h03);
      chk("alu_b", 32'(alu_b), 32'h03);
      chk("alu_en_exec", 32'(alu_en), 32'd1);
      tick();
      chk("alu_en_drop", 32'(alu_en), 32'd0);
      for (int i = 0; i < 20 && !tx_valid; i++) tick();
      chk("lo_valid", 32'(tx_valid), 32'd1);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(tx_valid === 1'b1 && tx_data === 8'h4B)) stable = 1'b0;
      end
      chk("lo_hold_10", 32'(stable), 32'd1);
      recv_byte("lo_4B", 8'h4B);
      recv_byte("hi_00", 8'h00);
      chk("tx_valid_after_hi", 32'(tx_valid), 32'd0);
      chk("busy_after_frame", 32'(busy), 32'd0);
      chk("en_count_1", 32'(en_cnt), 32'd1);
      chk("operands_hold", {20'd0, alu_fun, alu_a}, {20'd0, 4'hC, 8'h96});

      // Bad command tag in IDLE
      send_byte(8'h5C);
      chk("bad_tag_err", 32'(cmd_err), 32'd1);
      chk("bad_tag_busy", 32'(busy), 32'd0);
      tick();
      chk("bad_tag_pulse", 32'(cmd_err), 32'd0);
      chk("bad_tag_no_en", 32'(en_cnt), 32'd1);
      chk("bad_tag_no_tx", 32'(tx_valid), 32'd0);

      // Asynchronous reset while waiting for the result
      alu_hold = 1'b1;
      send_byte(8'hA3);
      send_byte(8'h44);
      send_byte(8'h55);
      tick();
      tick();
      chk("wait_res_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, cmd_err}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      alu_hold = 1'b0;
      tick();
      tick();
      chk("no_reissue", {30'd0, tx_valid, busy}, 32'd0);

      // Frame A1 05 07 after reset, stray byte during SEND_HI
      alu_ret = 16'hFFFE;
      send_byte(8'hA1);
      send_byte(8'h05);
      send_byte(8'h07);
      chk("frame2_ops", {12'd0, alu_fun, alu_a, alu_b}, {12'd0, 4'h1, 8'h05, 8'h07});
      recv_byte("lo_FE", 8'hFE);
      send_byte(8'h5C);
      chk("stray_no_err", 32'(cmd_err), 32'd0);
      chk("stray_hi_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hFF});
      recv_byte("hi_FF", 8'hFF);
      chk("frame2_done", {30'd0, tx_valid, busy}, 32'd0);

      // Back-to-back command the cycle after SEND_HI acceptance
      alu_ret = 16'h0030;
      send_byte(8'hA2);
      chk("b2b_accept", {27'd0, busy, alu_fun}, {27'd0, 1'b1, 4'h2});
      send_byte(8'h10);
      send_byte(8'h20);
      recv_byte("lo_30", 8'h30);
      recv_byte("hi_00b", 8'h00);
      chk("b2b_done", {30'd0, tx_valid, busy}, 32'd0);
      chk("en_count_4", 32'(en_cnt), 32'd4);

`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
      // Command then silence: cmd_err 255 cycles after the last byte
      send_byte(8'hA2);
      for (int i = 0; i < 253; i++) tick();
      chk("to_early", {30'd0, cmd_err, busy}, {30'd0, 1'b0, 1'b1});
      tick();
      chk("to_fire", {30'd0, cmd_err, busy}, {30'd0, 1'b1, 1'b0});
      tick();
      chk("to_pulse", 32'(cmd_err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Command sequencer sitting between the UART RX/TX byte streams and the ALU (arithmetic/logic/compare/shift units).
- Collects a 3-byte command frame from RX: command, operand A, operand B.
- Fires the ALU for one cycle and waits for its registered result.
- Returns the result to TX as two bytes, low byte first.
- The only block that drives the ALU enable and function-select lines.

Parameters:
- DATA_WIDTH, 8: operand width and UART byte width.
- CMD_TAG, 4'hA: required upper nibble of a valid command byte.
- RES_LAT, 1: ALU result latency in clk cycles after alu_en, used when the valid flag is absent.
- TIMEOUT_CYC, 255: inter-byte timeout in cycles; only used with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  DATA_WIDTH  received byte.
- rx_valid  in  1  one-cycle pulse; rx_data is valid.
- alu_a  out  DATA_WIDTH  operand A to ALU, registered.
- alu_b  out  DATA_WIDTH  operand B to ALU, registered.
- alu_fun  out  4  ALU function select, registered.
- alu_en  out  1  one-cycle ALU enable pulse.
- alu_out  in  2*DATA_WIDTH  ALU registered result.
- alu_out_valid  in  1  ALU result-valid flag, registered by the ALU.
- tx_data  out  DATA_WIDTH  byte to transmitter.
- tx_valid  out  1  byte available for TX.
- tx_ready  in  1  transmitter can accept a byte.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  one-cycle pulse: bad command byte or timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, cmd_err.
  - Result holding register cleared.
  - Reset mid-frame or mid-transmit abandons the operation; no partial TX byte is re-issued.
- States: IDLE, GET_A, GET_B, EXEC, WAIT_RES, SEND_LO, SEND_HI.
- IDLE:
  - On rx_valid with rx_data[7:4]==CMD_TAG: latch alu_fun<=rx_data[3:0], go to GET_A.
  - On rx_valid with a wrong tag: pulse cmd_err for 1 cycle and stay in IDLE.
- GET_A: on rx_valid, alu_a<=rx_data, go to GET_B.
- GET_B: on rx_valid, alu_b<=rx_data, go to EXEC.
- EXEC: alu_en=1 for exactly one cycle, then go to WAIT_RES.
- WAIT_RES:
  - On alu_out_valid=1, capture alu_out into the holding register and go to SEND_LO.
  - alu_out_valid is expected RES_LAT cycles after alu_en.
  - Without alu_out_valid, the block waits indefinitely unless the timeout feature is enabled.
- SEND_LO:
  - tx_data=result[DATA_WIDTH-1:0], tx_valid=1.
  - tx_valid is held until a cycle with tx_valid&&tx_ready, then go to SEND_HI.
- SEND_HI: same handshake with result[2*DATA_WIDTH-1:DATA_WIDTH], then go to IDLE.
- Handshake rules:
  - tx_valid never drops before acceptance.
  - tx_data is stable while tx_valid=1.
  - tx_valid is low in the cycle after the SEND_HI acceptance.
- Bytes arriving outside IDLE/GET_A/GET_B:
  - rx_valid in EXEC, WAIT_RES, SEND_LO or SEND_HI is dropped silently.
  - No cmd_err is raised for it.
- alu_a, alu_b and alu_fun hold their values after EXEC until the next frame overwrites them.
- Back-to-back frames: a command byte arriving the cycle after SEND_HI acceptance is accepted in IDLE.
- Throughput floor: minimum frame-to-result latency is 3 RX bytes + 1 (EXEC) + RES_LAT + 2 TX handshakes.

Optional Feature:
- Macro: ALU_SEQ_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in GET_A, GET_B and WAIT_RES, and clears on every rx_valid and on every state entry.
  - When the counter reaches TIMEOUT_CYC: pulse cmd_err and return to IDLE.
  - Operand registers keep their partial values.
- Undefined:
  - No counter is built; those states wait forever.
  - cmd_err only flags bad command tags.

Decomposition:
- Shared package alu_pkg holds:
  - State encoding enum for alu_seq_ctrl.
  - CMD_TAG constant.
  - ALU function codes; shift codes occupy alu_fun[3:2]=2'b11, with [1:0] selecting A>>1, A<<1, B>>1, B<<1.
- One natural sub-module: alu_seq_tx_ser, the two-byte TX serializer (SEND_LO/SEND_HI handshake), instantiated once.
- Everything else stays flat.

Test Plan:
- rx bytes 0xAC, 0x96, 0x03 → alu_fun=4'hC, alu_a=0x96, alu_b=0x03, one alu_en pulse. With ALU model returning 0x004B: tx bytes 0x4B then 0x00, busy low afterwards.
- rx byte 0x5C in IDLE → cmd_err pulse, state stays IDLE, no alu_en, no tx_valid.
- tx_ready held low for 10 cycles in SEND_LO → tx_valid stays high with tx_data constant at 0x4B; accepted on the first tx_ready=1 cycle.
- rst_n asserted during WAIT_RES → all outputs 0 immediately (async). Next frame 0xA1, 0x05, 0x07 completes normally.
- rx_valid pulse during SEND_HI → byte ignored, no cmd_err, frame completes with correct bytes.
- With ALU_SEQ_CTRL_TIMEOUT_EN, TIMEOUT_CYC=255: command 0xA2 then silence → cmd_err exactly 255 cycles after the last rx_valid, state IDLE.
